keystream_block_sched: RTL

- Sequencing controller for keystream generation: requests ChaCha20 state-matrix blocks from the block core, one incrementing block counter per request.
- Streams each 64-byte serialised matrix into the byte-wide keystream buffer under valid/ready handshake.
- Requests a buffer drain whenever NUM_MATRICES blocks are stored, or at end of job with a partially filled buffer.
- Sits between the top-level AEAD control FSM and the core/serialiser/buffer datapath.

---
 rtl/keystream_block_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/keystream_block_sched.sv
// Keystream block scheduler: requests state-matrix blocks from the block core,
// streams each serialised 64-byte block into the keystream buffer, and requests drains.
module keystream_block_sched #(
  parameter int NUM_MATRICES    = 20,
  parameter int BYTES_PER_BLOCK = 64,
  parameter int CORE_TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] init_counter,
  input  logic [15:0] num_blocks,
  output logic        core_start,
  output logic [31:0] core_counter,
  input  logic        core_done,
  output logic [5:0]  byte_idx,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        drain_req,
  input  logic        drain_ack,
  output logic        busy,
  output logic        done,
  output logic        wrap_err,
  output logic        timeout_err
);

  localparam int TW = $clog2(CORE_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CORE_TIMEOUT - 1);
  localparam logic [7:0]    BUF_FULL   = 8'(NUM_MATRICES);
  localparam logic [5:0]    LAST_BYTE  = 6'(BYTES_PER_BLOCK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_CORE, S_STREAM, S_DRAIN, S_FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   ctr_q, ctr_d;
  logic [15:0]   remaining_q, remaining_d;
  logic [7:0]    buf_blocks_q, buf_blocks_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [5:0]    byte_idx_q, byte_idx_d;
  logic          wrap_err_q, wrap_err_d;
  logic          timeout_err_q, timeout_err_d;

  logic [15:0]   rem_new;
  logic [7:0]    buf_new;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      ctr_q         <= '0;
      remaining_q   <= '0;
      buf_blocks_q  <= '0;
      timer_q       <= '0;
      byte_idx_q    <= '0;
      wrap_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctr_q         <= ctr_d;
      remaining_q   <= remaining_d;
      buf_blocks_q  <= buf_blocks_d;
      timer_q       <= timer_d;
      byte_idx_q    <= byte_idx_d;
      wrap_err_q    <= wrap_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    ctr_d         = ctr_q;
    remaining_d   = remaining_q;
    buf_blocks_d  = buf_blocks_q;
    timer_d       = timer_q;
    byte_idx_d    = byte_idx_q;
    wrap_err_d    = wrap_err_q;
    timeout_err_d = timeout_err_q;
    rem_new       = (remaining_q == 16'd0) ? 16'd0 : remaining_q - 16'd1;
    buf_new       = (buf_blocks_q == 8'hFF) ? buf_blocks_q : buf_blocks_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ctr_d         = init_counter;
          remaining_d   = num_blocks;
          buf_blocks_d  = '0;
          wrap_err_d    = 1'b0;
          timeout_err_d = 1'b0;
          state_d       = (num_blocks == 16'd0) ? S_FINISH : S_REQ;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT_CORE;
      end
      S_WAIT_CORE: begin
        if (core_done) begin
          byte_idx_d = '0;
          state_d    = S_STREAM;
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_STREAM: begin
        if (byte_ready) begin
          if (byte_idx_q == LAST_BYTE) begin
            byte_idx_d   = '0;
            remaining_d  = rem_new;
            buf_blocks_d = buf_new;
            // The final block of a job never advances the counter, so only
            // a mid-job all-ones counter is a wrap.
            if (rem_new != 16'd0 && ctr_q == 32'hFFFF_FFFF) begin
              wrap_err_d = 1'b1;
              state_d    = S_IDLE;
            end else begin
              if (rem_new != 16'd0) ctr_d = ctr_q + 32'd1;
              if (buf_new == BUF_FULL)    state_d = S_DRAIN;
              else if (rem_new == 16'd0)  state_d = S_FINISH;
              else                        state_d = S_REQ;
            end
          end else begin
            byte_idx_d = byte_idx_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_ack) begin
          buf_blocks_d = '0;
          state_d      = (remaining_q == 16'd0) ? S_FINISH : S_REQ;
        end
      end
      S_FINISH: begin
        state_d = (buf_blocks_q != 8'd0) ? S_DRAIN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort freezes all bookkeeping, including error flags, and only moves the FSM home.
    if (abort) begin
      state_d       = S_IDLE;
      ctr_d         = ctr_q;
      remaining_d   = remaining_q;
      buf_blocks_d  = buf_blocks_q;
      timer_d       = timer_q;
      byte_idx_d    = byte_idx_q;
      wrap_err_d    = wrap_err_q;
      timeout_err_d = timeout_err_q;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign core_start   = (state_q == S_REQ);
  assign core_counter = (state_q == S_REQ || state_q == S_WAIT_CORE) ? ctr_q : 32'd0;
  assign byte_valid   = (state_q == S_STREAM);
  assign byte_idx     = (state_q == S_STREAM) ? byte_idx_q : 6'd0;
  assign drain_req    = (state_q == S_DRAIN);
  assign done         = (state_q == S_FINISH) && (buf_blocks_q == 8'd0);
  assign wrap_err     = wrap_err_q;
  assign timeout_err  = timeout_err_q;

endmodule
